// File: rtl/ctrl_nest.sv
// Pipeline control unit: stall/flush generation, control-register file,
// nested-exception save stack and a prioritised multi-channel interrupt front end.
module ctrl_nest #(
  parameter int IRQ_CH     = 8,
  parameter int NEST_DEPTH = 4,
  parameter int ADDR_W     = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        creg_rd_addr,
  output logic [31:0]       creg_rd_data,
  input  logic [IRQ_CH-1:0] irq,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_en,
  input  logic              mem_br_flag,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [4:0]        mem_dst_addr,
  input  logic [31:0]       mem_wr_data,
  input  logic [2:0]        mem_exp_code,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              exe_mode,
  output logic              int_detect,
  output logic [4:0]        int_ch,
  output logic              nest_ovf
);

  localparam int IW = $clog2(NEST_DEPTH);
  localparam int DW = IW + 1;
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1'b1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(NEST_DEPTH);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NEST_DEPTH - 1);
  localparam logic [1:0]    OP_EXRT    = 2'd1;
  localparam logic [1:0]    OP_WRCR    = 2'd2;

  typedef struct packed {
    logic              mode;
    logic              ien;
    logic [ADDR_W-1:0] epc;
    logic [2:0]        code;
    logic              dly;
  } entry_t;

  logic              mode_r;
  logic              int_en_r;
  logic [DW-1:0]     depth_r;
  logic              ovf_r;
  logic [IRQ_CH-1:0] mask_r;
  logic [IRQ_CH-1:0] irq_mode_r;
  logic [IRQ_CH-1:0] pend_r;
  logic [IRQ_CH-1:0] irq_d_r;
  logic [ADDR_W-1:0] exp_vec_r;
  logic [ADDR_W-1:0] pre_pc_r;
  logic              br_flag_r;
  entry_t            stack_r [NEST_DEPTH];

  logic              stall_s;
  logic              commit_s;
  logic              is_exp_s;
  logic              is_exrt_s;
  logic              is_wrcr_s;
  logic              full_s;
  logic [IW-1:0]     top_s;
  logic [IW-1:0]     push_idx_s;
  entry_t            top_e_s;
  logic              flush_s;
  logic [ADDR_W-1:0] new_pc_s;
  logic [IRQ_CH-1:0] pend_set_s;
  logic [IRQ_CH-1:0] pend_clr_s;
  logic [IRQ_CH-1:0] eff_pend_s;
  logic [IRQ_CH-1:0] req_s;
  logic [4:0]        int_ch_s;
  logic [31:0]       rd_data_s;

  assign stall_s    = if_busy | mem_busy;
  assign commit_s   = mem_en & ~stall_s;
  assign is_exp_s   = (mem_exp_code != 3'd0);
  assign is_exrt_s  = ~is_exp_s & (mem_ctrl_op == OP_EXRT);
  assign is_wrcr_s  = ~is_exp_s & (mem_ctrl_op == OP_WRCR);
  assign full_s     = (depth_r == DEPTH_FULL);
  // An empty stack still exposes slot 0 so EXRT at depth 0 has a defined target.
  assign top_s      = (depth_r == {DW{1'b0}}) ? {IW{1'b0}} : IW'(depth_r - DEPTH_ONE);
  assign push_idx_s = full_s ? LAST_IDX : depth_r[IW-1:0];
  assign top_e_s    = stack_r[top_s];

  assign if_stall  = stall_s | ld_hazard;
  assign id_stall  = stall_s;
  assign ex_stall  = stall_s;
  assign mem_stall = stall_s;
  assign if_flush  = flush_s;
  assign id_flush  = flush_s | ld_hazard;
  assign ex_flush  = flush_s;
  assign mem_flush = flush_s;
  assign new_pc    = new_pc_s;
  assign exe_mode  = mode_r;
  assign nest_ovf  = ovf_r;

  // Redirect selection for the instruction sitting in MEM.
  always_comb begin
    flush_s  = 1'b0;
    new_pc_s = {ADDR_W{1'b0}};
    if (mem_en && is_exp_s) begin
      flush_s  = 1'b1;
      new_pc_s = exp_vec_r;
    end else if (mem_en && is_exrt_s) begin
      flush_s  = 1'b1;
      new_pc_s = top_e_s.epc;
    end else if (mem_en && is_wrcr_s) begin
      flush_s  = 1'b1;
      new_pc_s = mem_pc;
    end else begin
      flush_s  = 1'b0;
      new_pc_s = {ADDR_W{1'b0}};
    end
  end

  assign pend_set_s = irq & ~irq_d_r & irq_mode_r;
  assign pend_clr_s = (commit_s && is_wrcr_s && mem_dst_addr == 5'd8) ?
                      mem_wr_data[IRQ_CH-1:0] : {IRQ_CH{1'b0}};
  assign eff_pend_s = (pend_r & irq_mode_r) | (irq & ~irq_mode_r);
  assign req_s      = eff_pend_s & ~mask_r;
  assign int_detect = int_en_r & (|req_s);
  assign int_ch     = int_ch_s;

  // Lowest-index unmasked request wins.
  always_comb begin
    int_ch_s = 5'd0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        int_ch_s = 5'(i);
      end else begin
        int_ch_s = int_ch_s;
      end
    end
  end

  // Control-register read mux.
  always_comb begin
    rd_data_s = 32'd0;
    case (creg_rd_addr)
      5'd0:    rd_data_s = 32'({int_en_r, mode_r});
      5'd1:    rd_data_s = 32'({top_e_s.ien, top_e_s.mode});
      5'd2:    rd_data_s = 32'({id_pc, 2'b00});
      5'd3:    rd_data_s = 32'({top_e_s.epc, 2'b00});
      5'd4:    rd_data_s = 32'({exp_vec_r, 2'b00});
      5'd5:    rd_data_s = 32'({top_e_s.dly, top_e_s.code});
      5'd6:    rd_data_s = 32'(mask_r);
      5'd7:    rd_data_s = 32'(irq);
      5'd8:    rd_data_s = 32'(pend_r);
      5'd9:    rd_data_s = 32'(irq_mode_r);
      5'd10:   rd_data_s = 32'({ovf_r, depth_r});
      5'd11:   rd_data_s = {16'(IRQ_CH), 16'(NEST_DEPTH)};
      default: rd_data_s = 32'd0;
    endcase
  end

  assign creg_rd_data = rd_data_s;

  // Architectural state: interrupt sampling every cycle, the rest on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r     <= 1'b0;
      int_en_r   <= 1'b0;
      depth_r    <= {DW{1'b0}};
      ovf_r      <= 1'b0;
      mask_r     <= {IRQ_CH{1'b1}};
      irq_mode_r <= {IRQ_CH{1'b0}};
      pend_r     <= {IRQ_CH{1'b0}};
      irq_d_r    <= {IRQ_CH{1'b0}};
      exp_vec_r  <= {ADDR_W{1'b0}};
      pre_pc_r   <= {ADDR_W{1'b0}};
      br_flag_r  <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stack_r[i] <= {$bits(entry_t){1'b0}};
      end
    end else begin
      irq_d_r <= irq;
      pend_r  <= (pend_r & ~pend_clr_s) | pend_set_s;
      if (commit_s) begin
        pre_pc_r  <= mem_pc;
        br_flag_r <= mem_br_flag;
        if (is_exp_s) begin
          stack_r[push_idx_s] <= '{mode: mode_r, ien: int_en_r, epc: pre_pc_r,
                                   code: mem_exp_code, dly: br_flag_r};
          mode_r   <= 1'b0;
          int_en_r <= 1'b0;
          if (full_s) begin
            ovf_r <= 1'b1;
          end else begin
            depth_r <= depth_r + DEPTH_ONE;
          end
        end else if (is_exrt_s) begin
          if (depth_r != {DW{1'b0}}) begin
            mode_r   <= top_e_s.mode;
            int_en_r <= top_e_s.ien;
            depth_r  <= depth_r - DEPTH_ONE;
          end
        end else if (is_wrcr_s) begin
          case (mem_dst_addr)
            5'd0: {int_en_r, mode_r} <= mem_wr_data[1:0];
            5'd1: {stack_r[top_s].ien, stack_r[top_s].mode} <= mem_wr_data[1:0];
            5'd3: stack_r[top_s].epc <= mem_wr_data[ADDR_W+1:2];
            5'd4: exp_vec_r <= mem_wr_data[ADDR_W+1:2];
            5'd5: {stack_r[top_s].dly, stack_r[top_s].code} <= mem_wr_data[3:0];
            5'd6: mask_r <= mem_wr_data[IRQ_CH-1:0];
            5'd9: irq_mode_r <= mem_wr_data[IRQ_CH-1:0];
            5'd10: begin
              if (mem_wr_data[31]) begin
                ovf_r <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_nest.sv
// Directed + randomized bench for ctrl_nest, checked against an array-based
// behavioural model of the control unit.
module tb_ctrl_nest;
  localparam int ND  = 4;
  localparam int NCH = 8;
  localparam int AW  = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    creg_rd_addr;
  logic [31:0]   creg_rd_data;
  logic [NCH-1:0] irq;
  logic [AW-1:0] id_pc, mem_pc;
  logic          mem_en, mem_br_flag;
  logic [1:0]    mem_ctrl_op;
  logic [4:0]    mem_dst_addr;
  logic [31:0]   mem_wr_data;
  logic [2:0]    mem_exp_code;
  logic          if_busy, mem_busy, ld_hazard;
  logic          if_stall, id_stall, ex_stall, mem_stall;
  logic          if_flush, id_flush, ex_flush, mem_flush;
  logic [AW-1:0] new_pc;
  logic          exe_mode, int_detect, nest_ovf;
  logic [4:0]    int_ch;

  ctrl_nest #(.IRQ_CH(NCH), .NEST_DEPTH(ND), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .irq(irq), .id_pc(id_pc), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
    .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_wr_data(mem_wr_data),
    .mem_exp_code(mem_exp_code), .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .exe_mode(exe_mode), .int_detect(int_detect), .int_ch(int_ch),
    .nest_ovf(nest_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mode;
    logic          ien;
    logic [AW-1:0] epc;
    logic [2:0]    code;
    logic          dly;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic           m_mode, m_ien, m_ovf, m_br;
  int             m_depth;
  logic [NCH-1:0] m_mask, m_imode, m_pend, m_irq_d;
  logic [AW-1:0]  m_vec, m_pre_pc;
  ent_t           stk [ND];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int top_idx();
    return (m_depth == 0) ? 0 : m_depth - 1;
  endfunction

  function automatic logic [31:0] exp_creg(input logic [4:0] a);
    ent_t t;
    t = stk[top_idx()];
    case (a)
      5'd0:    return {30'd0, m_ien, m_mode};
      5'd1:    return {30'd0, t.ien, t.mode};
      5'd2:    return {id_pc, 2'b00};
      5'd3:    return {t.epc, 2'b00};
      5'd4:    return {m_vec, 2'b00};
      5'd5:    return {28'd0, t.dly, t.code};
      5'd6:    return {24'd0, m_mask};
      5'd7:    return {24'd0, irq};
      5'd8:    return {24'd0, m_pend};
      5'd9:    return {24'd0, m_imode};
      5'd10:   return 32'(m_depth) + (m_ovf ? 32'd8 : 32'd0);
      5'd11:   return 32'h0008_0004;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 1'b0; m_ien = 1'b0; m_ovf = 1'b0; m_br = 1'b0; m_depth = 0;
    m_mask = 8'hFF; m_imode = 8'h00; m_pend = 8'h00; m_irq_d = 8'h00;
    m_vec = '0; m_pre_pc = '0;
    for (int i = 0; i < ND; i++) stk[i] = '0;
  endtask

  task automatic check_outputs();
    logic           stall, fl;
    logic [AW-1:0]  npc;
    logic [NCH-1:0] req;
    int             ch;
    stall = if_busy | mem_busy;
    fl = mem_en && (mem_exp_code != 3'd0 || mem_ctrl_op == 2'd1 || mem_ctrl_op == 2'd2);
    if (!mem_en)                  npc = '0;
    else if (mem_exp_code != 3'd0) npc = m_vec;
    else if (mem_ctrl_op == 2'd1) npc = stk[top_idx()].epc;
    else if (mem_ctrl_op == 2'd2) npc = mem_pc;
    else                          npc = '0;
    req = ((m_pend & m_imode) | (irq & ~m_imode)) & ~m_mask;
    ch = 0;
    for (int i = NCH - 1; i >= 0; i--) if (req[i]) ch = i;
    chk("if_stall",   32'(if_stall),   32'(stall | ld_hazard));
    chk("id_stall",   32'(id_stall),   32'(stall));
    chk("ex_stall",   32'(ex_stall),   32'(stall));
    chk("mem_stall",  32'(mem_stall),  32'(stall));
    chk("if_flush",   32'(if_flush),   32'(fl));
    chk("id_flush",   32'(id_flush),   32'(fl | ld_hazard));
    chk("ex_flush",   32'(ex_flush),   32'(fl));
    chk("mem_flush",  32'(mem_flush),  32'(fl));
    chk("new_pc",     32'(new_pc),     32'(npc));
    chk("int_detect", 32'(int_detect), 32'(m_ien & (req != '0)));
    chk("int_ch",     32'(int_ch),     32'(ch));
    chk("exe_mode",   32'(exe_mode),   32'(m_mode));
    chk("nest_ovf",   32'(nest_ovf),   32'(m_ovf));
    chk("creg_rd",    creg_rd_data,    exp_creg(creg_rd_addr));
  endtask

  task automatic model_step();
    logic           commit;
    logic [NCH-1:0] clr;
    ent_t           e;
    int             t;
    commit = mem_en & ~(if_busy | mem_busy);
    clr = '0;
    if (commit && mem_exp_code == 3'd0 && mem_ctrl_op == 2'd2 && mem_dst_addr == 5'd8)
      clr = mem_wr_data[NCH-1:0];
    m_pend  = (m_pend & ~clr) | (irq & ~m_irq_d & m_imode);
    m_irq_d = irq;
    if (commit) begin
      if (mem_exp_code != 3'd0) begin
        e.mode = m_mode; e.ien = m_ien; e.epc = m_pre_pc; e.code = mem_exp_code; e.dly = m_br;
        if (m_depth == ND) begin
          stk[ND-1] = e;
          m_ovf = 1'b1;
        end else begin
          stk[m_depth] = e;
          m_depth++;
        end
        m_mode = 1'b0;
        m_ien  = 1'b0;
      end else if (mem_ctrl_op == 2'd1) begin
        if (m_depth > 0) begin
          m_depth--;
          m_mode = stk[m_depth].mode;
          m_ien  = stk[m_depth].ien;
        end
      end else if (mem_ctrl_op == 2'd2) begin
        t = top_idx();
        case (mem_dst_addr)
          5'd0: {m_ien, m_mode} = mem_wr_data[1:0];
          5'd1: begin stk[t].ien = mem_wr_data[1]; stk[t].mode = mem_wr_data[0]; end
          5'd3: stk[t].epc = mem_wr_data[31:2];
          5'd4: m_vec = mem_wr_data[31:2];
          5'd5: begin stk[t].dly = mem_wr_data[3]; stk[t].code = mem_wr_data[2:0]; end
          5'd6: m_mask = mem_wr_data[NCH-1:0];
          5'd9: m_imode = mem_wr_data[NCH-1:0];
          5'd10: if (mem_wr_data[31]) m_ovf = 1'b0;
          default: ;
        endcase
      end
      m_pre_pc = mem_pc;
      m_br     = mem_br_flag;
    end
  endtask

  // One clock: check combinational/registered outputs, advance model, cross the edge.
  task automatic cyc();
    #2;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en = 1'b0; mem_ctrl_op = 2'd0; mem_exp_code = 3'd0; mem_dst_addr = 5'd0;
    mem_wr_data = 32'd0; mem_pc = '0; mem_br_flag = 1'b0;
    if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
    mem_en = 1'b1; mem_ctrl_op = 2'd2; mem_dst_addr = a; mem_wr_data = d;
    mem_exp_code = 3'd0; mem_pc = '0;
    cyc();
    idle();
  endtask

  task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
    creg_rd_addr = a;
    #1;
    chk(tag, creg_rd_data, exp);
  endtask

  initial begin
    idle();
    irq = '0; id_pc = 30'h0000_1234; creg_rd_addr = 5'd0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_exe_mode", 32'(exe_mode), 32'd0);
    peek(5'd0,  "rst_status", 32'd0);
    peek(5'd6,  "rst_mask",   32'h0000_00FF);
    peek(5'd10, "rst_nest",   32'd0);
    chk("rst_flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'd0);
    peek(5'd11, "cpu_info",   32'h0008_0004);
    cyc();

    // Edge-mode channel 0 with sticky pending and write-1-clear
    wrcr(5'd0, 32'h3);
    wrcr(5'd6, 32'hFE);
    wrcr(5'd9, 32'h1);
    irq = 8'h01;
    cyc();
    irq = 8'h00;
    peek(5'd8, "pend0_set", 32'h1);
    chk("edge_int_detect", 32'(int_detect), 32'd1);
    chk("edge_int_ch",     32'(int_ch),     32'd0);
    cyc();
    wrcr(5'd8, 32'h1);
    peek(5'd8, "pend0_clr", 32'h0);
    chk("clr_int_detect", 32'(int_detect), 32'd0);

    // Level channels, priority follows raw irq within the cycle
    wrcr(5'd9, 32'h0);
    wrcr(5'd6, 32'h0);
    irq = 8'h0C;
    #1;
    chk("lvl_int_ch2", 32'(int_ch), 32'd2);
    irq = 8'h08;
    #1;
    chk("lvl_int_ch3", 32'(int_ch), 32'd3);
    cyc();
    irq = 8'h00;
    cyc();

    // Single exception
    wrcr(5'd4, 32'h100);
    mem_en = 1'b1; mem_pc = 30'h100;
    cyc();
    mem_exp_code = 3'd3; mem_pc = 30'h200;
    #1;
    chk("exp_new_pc", 32'(new_pc), 32'h40);
    chk("exp_flush",  32'({if_flush, id_flush, ex_flush, mem_flush}), 32'hF);
    cyc();
    idle();
    #1;
    chk("exp_flush_drop", 32'(if_flush), 32'd0);
    peek(5'd3,  "exp_epc",   32'h400);
    peek(5'd5,  "exp_cause", 32'h3);
    peek(5'd10, "exp_depth", 32'h1);
    chk("exp_mode", 32'(exe_mode), 32'd0);
    cyc();

    // Nested exception and two returns
    wrcr(5'd0, 32'h1);
    mem_en = 1'b1; mem_pc = 30'h300;
    cyc();
    mem_exp_code = 3'd5; mem_pc = 30'h304;
    cyc();
    idle();
    peek(5'd10, "nest_depth2", 32'h2);
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_pc = 30'h308;
    #1;
    chk("exrt1_pc", 32'(new_pc), 32'h300);
    cyc();
    idle();
    peek(5'd0,  "exrt1_status", 32'h1);
    peek(5'd10, "exrt1_depth",  32'h1);
    cyc();
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_pc = 30'h30C;
    #1;
    chk("exrt2_pc", 32'(new_pc), 32'h100);
    cyc();
    idle();
    peek(5'd0,  "exrt2_status", 32'h3);
    peek(5'd10, "exrt2_depth",  32'h0);
    cyc();

    // Overflow of the save stack, then EXRT held off by mem_busy
    for (int i = 0; i < ND + 1; i++) begin
      mem_en = 1'b1; mem_exp_code = 3'(i + 1); mem_pc = 30'(32'h500 + i);
      cyc();
      idle();
    end
    chk("ovf_flag", 32'(nest_ovf), 32'd1);
    peek(5'd10, "ovf_nest", 32'hC);
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_busy = 1'b1;
    repeat (3) cyc();
    chk("busy_stall", 32'({if_stall, mem_stall}), 32'h3);
    peek(5'd10, "busy_hold", 32'hC);
    mem_busy = 1'b0;
    cyc();
    idle();
    peek(5'd10, "busy_pop", 32'hB);
    wrcr(5'd10, 32'h8000_0000);
    peek(5'd10, "ovf_clr", 32'h3);
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      mem_en       = ($urandom_range(0, 3) != 0);
      mem_exp_code = ($urandom_range(0, 15) < 2) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_ctrl_op  = 2'($urandom_range(0, 3));
      mem_dst_addr = 5'($urandom_range(0, 12));
      mem_wr_data  = $urandom;
      mem_pc       = 30'($urandom);
      id_pc        = 30'($urandom);
      mem_br_flag  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      if_busy      = ($urandom_range(0, 7) == 0);
      mem_busy     = ($urandom_range(0, 7) == 0);
      ld_hazard    = ($urandom_range(0, 7) == 0);
      creg_rd_addr = 5'($urandom_range(0, 15));
      cyc();
    end

    idle();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_nest.md
Name: ctrl_nest

Overview:
Parametrised successor of the CPU pipeline control unit. It generates stall and flush signals, holds the control-register file, and redirects the PC on exception, EXRT and WRCR. Two additions over the previous unit: a hardware save stack (nested exceptions, depth NEST_DEPTH) and an IRQ_CH-channel interrupt front end (per-channel edge/level mode, sticky pending, lowest-index priority). It sits beside the MEM stage and drives every pipeline register's stall and flush inputs.

Parameters:
IRQ_CH, 8, interrupt channels (1..32)
NEST_DEPTH, 4, save-stack entries (power of 2, >=2)
ADDR_W, 30, word-address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
creg_rd_addr  in  5  control-register read address
creg_rd_data  out  32  control-register read data (combinational)
irq  in  IRQ_CH  raw interrupt requests
id_pc  in  ADDR_W  ID-stage PC
mem_pc  in  ADDR_W  MEM-stage PC
mem_en  in  1  MEM stage valid
mem_br_flag  in  1  MEM instruction is a taken branch
mem_ctrl_op  in  2  0 none, 1 EXRT, 2 WRCR
mem_dst_addr  in  5  WRCR target register
mem_wr_data  in  32  WRCR data
mem_exp_code  in  3  0 = no exception
if_busy, mem_busy, ld_hazard  in  1 each  stall sources
if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage stalls
if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage flushes
new_pc  out  ADDR_W  redirect target
exe_mode  out  1  0 kernel, 1 user
int_detect  out  1  unmasked interrupt pending and enabled
int_ch  out  5  highest-priority pending channel
nest_ovf  out  1  sticky save-stack overflow

Behaviour:
- stall = if_busy|mem_busy. if_stall = stall|ld_hazard; id/ex/mem_stall = stall.
- flush (combinational, only when mem_en):
  - mem_exp_code!=0 -> new_pc=exp_vector.
  - else EXRT -> new_pc=stack[top].epc.
  - else WRCR -> new_pc=mem_pc.
  - Otherwise flush=0, new_pc=0.
  - All four flush outputs = flush; id_flush additionally ORs ld_hazard.
- Commit: state updates only when mem_en && !stall. pre_pc<=mem_pc and br_flag<=mem_br_flag on every commit.
- Exception commit (push):
  - Entry {exe_mode, int_en, epc=pre_pc, exp_code, dly_flag=br_flag} is written at index depth; depth++.
  - Then exe_mode<=kernel, int_en<=0.
  - If depth==NEST_DEPTH: entry NEST_DEPTH-1 is overwritten, depth unchanged, nest_ovf<=1.
- EXRT commit (pop): if depth>0, exe_mode/int_en are restored from stack[depth-1]; depth--. If depth==0: state unchanged, redirect still to stack[0].epc. top = depth==0 ? 0 : depth-1.
- WRCR commit writes registers by mem_dst_addr; read-only and unmapped addresses are ignored.
- Control-register map (R/W unless marked; write bits match read bits):
  - 0 STATUS {int_en, exe_mode}.
  - 1 PRE_STATUS: stack[top] {int_en, mode}.
  - 2 PC {id_pc, 00}, read-only.
  - 3 EPC: stack[top].epc<<2.
  - 4 EXP_VECTOR {exp_vector, 00}.
  - 5 CAUSE {dly_flag, exp_code} of top.
  - 6 INT_MASK (1 = masked).
  - 7 IRQ raw, read-only.
  - 8 IRQ_PEND; write-1-clears.
  - 9 IRQ_MODE (1 = edge).
  - 10 NEST {nest_ovf, depth}; writing bit 31 = 1 clears nest_ovf.
  - 11 CPU_INFO, read-only constant {IRQ_CH, NEST_DEPTH}.
  - Others read 0. All fields are zero-extended to 32 bits.
- Interrupt front end:
  - irq_d<=irq every cycle.
  - Edge channel: pend bit set on irq&~irq_d.
  - Level channel: effective pending = irq (the pend bit is ignored).
  - A set and a write-1-clear in the same cycle: set wins.
  - int_detect = int_en & |(eff_pend & ~mask).
  - int_ch = lowest index of eff_pend&~mask; 0 when none.
- Reset values:
  - exe_mode=kernel, int_en=0, depth=0, nest_ovf=0.
  - mask=all 1s, mode=0 (level), pend=0, irq_d=0.
  - exp_vector=0, pre_pc=0, br_flag=0, all stack entries 0.

Test Plan:
- Reset -> exe_mode=0, int_en=0, mask=0xFF, creg 10 reads 0, all flushes 0.
- WRCR STATUS=0x3, mask=0xFE, edge mode ch0, pulse irq[0] one cycle -> pend[0]=1, int_detect=1, int_ch=0; write-1 IRQ_PEND -> int_detect=0.
- irq=0x0C level, mask=0 -> int_ch=2; drop irq[2] -> int_ch=3 the same cycle.
- Exception code 3 with pre_pc=0x100, exp_vector=0x40 -> new_pc=0x40, all flushes 1 for one cycle; creg3=0x400, creg5=3, depth=1, exe_mode=0.
- Two nested exceptions then two EXRT -> first EXRT returns the inner epc, second returns the outer epc; STATUS is restored each time; depth ends at 0.
- NEST_DEPTH+1 exceptions -> nest_ovf=1, depth=NEST_DEPTH; mem_busy=1 during EXRT -> no state change until busy drops.
